msg_schedule_expander: RTL and testbench

//  Sequential SHA-2 message-schedule generator. Accepts the 16 block words W[0..15] over a valid/ready stream.

---
 rtl/msg_schedule_expander.sv | 104 ++++++++++
 tb/tb_msg_schedule_expander.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule_expander.sv
// msg_schedule_expander: sequential SHA-256/SHA-512 message-schedule generator (optional out_idx via SCHED_WIDX_EN)
module msg_schedule_expander #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              busy,
    output logic              done
`ifdef SCHED_WIDX_EN
    ,
    output logic [$clog2(ROUNDS)-1:0] out_idx
`endif
);
    localparam int T_W = $clog2(ROUNDS + 1);
    localparam bit WIDE = (WORD_W == 64);
    localparam int S0A = WIDE ? 1 : 7;
    localparam int S0B = WIDE ? 8 : 18;
    localparam int S0C = WIDE ? 7 : 3;
    localparam int S1A = WIDE ? 19 : 17;
    localparam int S1B = WIDE ? 61 : 19;
    localparam int S1C = WIDE ? 6 : 10;
    localparam logic [T_W-1:0] T_LOAD_END = T_W'(15);
    localparam logic [T_W-1:0] T_LAST = T_W'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t            state, state_nx;
    logic [T_W-1:0]    t;
    logic [WORD_W-1:0] win [16];
    logic              adv, ld, step, push;
    logic [WORD_W-1:0] w_calc, w_nx;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0A) ^ rotr(x, S0B) ^ (x >> S0C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1A) ^ rotr(x, S1B) ^ (x >> S1C);
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == LOAD) && adv;
    assign busy     = (state != IDLE);
    assign ld       = in_valid && in_ready;
    assign step     = (state == EXPAND) && adv;
    assign push     = ld || step;
    assign w_calc   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign w_nx     = ld ? in_word : w_calc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: start only matters in IDLE; LOAD ends on the 16th word, EXPAND on the last
    always_comb begin
        state_nx = state;
        if (state == IDLE && start)        state_nx = LOAD;
        else if (ld && t == T_LOAD_END)    state_nx = EXPAND;
        else if (step && t == T_LAST)      state_nx = IDLE;
    end

    // Window, counter and registered output stage; a new word replaces the output slot whenever it frees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
`ifdef SCHED_WIDX_EN
            out_idx   <= '0;
`endif
        end else begin
            done <= step && t == T_LAST;
            if (state == IDLE && start) t <= '0;
            if (push) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15]   <= w_nx;
                out_word  <= w_nx;
                out_valid <= 1'b1;
                t         <= t + T_W'(1);
`ifdef SCHED_WIDX_EN
                out_idx   <= t[$clog2(ROUNDS)-1:0];
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_msg_schedule_expander.sv
// tb_msg_schedule_expander: directed checks of SHA-256 and SHA-512 schedule generation
module tb_msg_schedule_expander;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_word = '0;
    logic        ir_a, ov_a, by_a, dn_a;
    logic        ir_b, ov_b, by_b, dn_b;
    logic [31:0] ow_a;
    logic [63:0] ow_b;
`ifdef SCHED_WIDX_EN
    logic [5:0]  idx_a;
    logic [6:0]  idx_b;
`endif

    logic [63:0] blk  [16];
    logic [63:0] expv [128];
    logic [63:0] got  [128];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msg_schedule_expander #(.WORD_W(32), .ROUNDS(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(ir_a),
        .in_word(in_word[31:0]), .out_valid(ov_a), .out_ready(out_ready), .out_word(ow_a),
        .busy(by_a), .done(dn_a)
`ifdef SCHED_WIDX_EN
        , .out_idx(idx_a)
`endif
    );

    msg_schedule_expander #(.WORD_W(64), .ROUNDS(80)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(ir_b),
        .in_word(in_word), .out_valid(ov_b), .out_ready(out_ready), .out_word(ow_b),
        .busy(by_b), .done(dn_b)
`ifdef SCHED_WIDX_EN
        , .out_idx(idx_b)
`endif
    );

    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [31:0] ss0_32(input logic [31:0] x);
        return rr32(x, 7) ^ rr32(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1_32(input logic [31:0] x);
        return rr32(x, 17) ^ rr32(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0] ss0_64(input logic [63:0] x);
        return rr64(x, 1) ^ rr64(x, 8) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] ss1_64(input logic [63:0] x);
        return rr64(x, 19) ^ rr64(x, 61) ^ (x >> 6);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: out_ready=1; mode 1: toggling with two 5-cycle stalls; mode 2: abandon after 20 words
    task automatic run_block(input bit wide, input int mode, input bit poke);
        int r, n_in, n_out, n_done;
        logic ir, ov, dn, by;
        logic [63:0] ow;
        r = wide ? 80 : 64;
        for (int i = 0; i < 16; i++) expv[i] = wide ? blk[i] : {32'h0, blk[i][31:0]};
        for (int i = 16; i < r; i++)
            expv[i] = wide ? ss1_64(expv[i-2]) + expv[i-7] + ss0_64(expv[i-15]) + expv[i-16]
                           : {32'h0, ss1_32(expv[i-2][31:0]) + expv[i-7][31:0]
                                     + ss0_32(expv[i-15][31:0]) + expv[i-16][31:0]};
        n_in = 0; n_out = 0; n_done = 0;
        for (int cyc = 0; cyc < 3000 && n_out < r; cyc++) begin
            @(negedge clk);
            start_a   = !wide && (cyc == 0 || (poke && (n_in == 8 || n_out == 30)));
            start_b   =  wide && (cyc == 0 || (poke && (n_in == 8 || n_out == 30)));
            out_ready = (mode == 1) ? (cyc % 2 == 0 && !(cyc >= 6 && cyc <= 10) && !(cyc >= 40 && cyc <= 44)) : 1'b1;
            in_valid  = n_in < 16;
            if (n_in < 16) in_word = blk[n_in];
            else           in_word = '0;
            #1;
            ir = wide ? ir_b : ir_a;
            ov = wide ? ov_b : ov_a;
            dn = wide ? dn_b : dn_a;
            by = wide ? by_b : by_a;
            ow = wide ? ow_b : {32'h0, ow_a};
            if (ov && !out_ready) chk("in_ready_blocked", {63'h0, ir}, 64'h0);
            if (dn) begin
                n_done++;
                chk("done_position", 64'(n_out), 64'(r - 1));
                chk("done_word", ow, expv[r-1]);
            end
            if (ov && out_ready) begin
                chk("word", ow, expv[n_out]);
`ifdef SCHED_WIDX_EN
                chk("out_idx", wide ? 64'(idx_b) : 64'(idx_a), 64'(n_out));
`endif
                got[n_out] = ow;
                n_out++;
            end
            if (ir && in_valid) n_in++;
            if (mode == 2 && n_out == 20) break;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        if (mode != 2) begin
            chk("word_count", 64'(n_out), 64'(r));
            chk("done_count", 64'(n_done), 64'h1);
            chk("busy_end", {63'h0, by}, 64'h0);
        end
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {62'h0, ov_a, ov_b}, 64'h0);
        chk("rst_busy", {62'h0, by_a, by_b}, 64'h0);
        chk("rst_done", {62'h0, dn_a, dn_b}, 64'h0);
        chk("rst_in_ready", {62'h0, ir_a, ir_b}, 64'h0);
        chk("rst_out_word", ow_b | {32'h0, ow_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SHA-256 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h61626380; blk[15] = 64'h18;
        run_block(1'b0, 0, 1'b0);
        chk("abc_w16", got[16], 64'h61626380);
        chk("abc_w17", got[17], 64'h000F0000);

        // sigma0 isolation
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[1] = 64'h1;
        run_block(1'b0, 0, 1'b0);
        chk("sigma0_w16", got[16], 64'h02004000);

        // backpressure with arbitrary data
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
        run_block(1'b0, 1, 1'b0);

        // start pokes during LOAD and EXPAND, then back-to-back block
        for (int i = 0; i < 16; i++) blk[i] = {32'h0, 32'h9E3779B9 * (i + 1)};
        run_block(1'b0, 0, 1'b1);
        for (int i = 0; i < 16; i++) blk[i] = {32'h0, 32'h01000193 ^ (32'h11 << i)};
        run_block(1'b0, 1, 1'b1);

        // reset mid-EXPAND
        run_block(1'b0, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'h0, ov_a}, 64'h0);
        chk("midrst_busy", {63'h0, by_a}, 64'h0);
        chk("midrst_done", {63'h0, dn_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h61626380; blk[15] = 64'h18;
        run_block(1'b0, 0, 1'b0);
        chk("postrst_w17", got[17], 64'h000F0000);

        // SHA-512 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h6162638000000000; blk[15] = 64'h18;
        run_block(1'b1, 0, 1'b0);
        chk("abc512_w16", got[16], 64'h6162638000000000);
        chk("abc512_w17", got[17], 64'h00030000000000C0);
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
        run_block(1'b1, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
